// File: rtl/pwm_bank_pkg.sv
// Shared helpers for the pwm_bank slice.
package pwm_bank_pkg;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned pwm_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned k = 1; k < n; k = k << 1) begin
      w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: duty shadow/active pair, phase offset and registered compare.
module pwm_bank_channel
  import pwm_bank_pkg::*;
#(
  parameter int unsigned BITS    = 8,
  parameter int unsigned OFFSET  = 0,
  parameter int unsigned PHASE_W = BITS + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [BITS-1:0] counter,
  input  logic [BITS-1:0] period_active,
  input  logic            wr,
  input  logic [BITS-1:0] wr_data,
  input  logic            load,
  output logic            out
);

  logic [BITS-1:0]    duty_shadow;
  logic [BITS-1:0]    duty_active;
  logic [PHASE_W-1:0] phase_raw;
  logic [PHASE_W-1:0] span;
  logic [PHASE_W-1:0] phase;

  // Offset the shared counter; a single conditional subtract folds it back into the period.
  always_comb begin
    phase_raw = PHASE_W'(counter) + PHASE_W'(OFFSET);
    span      = PHASE_W'(period_active) + PHASE_W'(1);
    phase     = phase_raw;
    if (phase_raw > PHASE_W'(period_active)) begin
      phase = phase_raw - span;
    end
  end

  // Shadow takes writes; active copies the pre-write shadow on load; output compare is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_shadow <= '0;
      duty_active <= '0;
      out         <= 1'b0;
    end else begin
      if (wr) begin
        duty_shadow <= wr_data;
      end
      if (load) begin
        duty_active <= duty_shadow;
      end
      out <= enable && (phase < PHASE_W'(duty_active));
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with programmable period and wrap-synchronous register updates.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int unsigned     CHANNELS       = 4,
  parameter int unsigned     BITS           = 8,
  parameter int unsigned     STAGGER        = 0,
  parameter logic [BITS-1:0] DEFAULT_PERIOD = '1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             wr_duty,
  input  logic [pwm_clog2(CHANNELS)-1:0]   wr_chan,
  input  logic                             wr_period,
  input  logic [BITS-1:0]                  wr_data,
  output logic [CHANNELS-1:0]              out,
  output logic                             sync,
  output logic                             pending
);

  localparam int unsigned CW      = pwm_clog2(CHANNELS);
  localparam int unsigned PHASE_W = BITS + CW + 1;

  logic [BITS-1:0] counter;
  logic [BITS-1:0] period_shadow;
  logic [BITS-1:0] period_active;
  logic            wrap;
  logic            load;
  logic            duty_wr_ok;

  assign wrap       = (counter == period_active);
  // While disabled every cycle is a load cycle, so re-enable starts from fresh active values.
  assign load       = wrap || !enable;
  assign duty_wr_ok = wr_duty && (32'(wr_chan) < CHANNELS);

  // Free-running counter over 0..period_active, parked at zero while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
    end else if (load) begin
      counter <= '0;
    end else begin
      counter <= counter + 1'b1;
    end
  end

  // Period shadow/active pair, pending flag and phase-zero strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_shadow <= DEFAULT_PERIOD;
      period_active <= DEFAULT_PERIOD;
      pending       <= 1'b0;
      sync          <= 1'b0;
    end else begin
      if (wr_period) begin
        period_shadow <= wr_data;
      end
      if (load) begin
        period_active <= period_shadow;
      end
      if (duty_wr_ok || wr_period) begin
        pending <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end
      sync <= (counter == '0) && enable;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_bank_channel #(
      .BITS    (BITS),
      .OFFSET  (i * STAGGER),
      .PHASE_W (PHASE_W)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .counter       (counter),
      .period_active (period_active),
      .wr            (duty_wr_ok && (wr_chan == CW'(i))),
      .wr_data       (wr_data),
      .load          (load),
      .out           (out[i])
    );
  end

endmodule
